// File: rtl/aes_sram_pkg.sv
// Shared types and helpers for the AES SRAM port arbiter.
// Holds width defaults, the FSM encoding and the round-robin picker.
package aes_sram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;
  localparam int MAX_REQ    = 8;
  localparam int RR_W       = 3;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } arb_state_t;

  // One-hot winner: first set bit of req scanning upward from ptr, mod n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [RR_W-1:0]    ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] w_gnt;
    logic               w_found;
    logic [RR_W-1:0]    w_idx;
    w_gnt   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      w_idx = RR_W'((32'(ptr) + i) % n);
      if (i < n && !w_found && req[w_idx]) begin
        w_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
    return w_gnt;
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address sequencer: latches base/length, counts beats,
// and flags the final beat of the burst.
module burst_addr_gen
  import aes_sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic [LEN_W-1:0]  o_beat_idx,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_base <= '0;
      r_len  <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_base <= i_base;
      r_len  <= i_len;
      r_idx  <= '0;
    end else if (i_step) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Address wraps naturally at 2^ADDR_W.
  assign o_addr     = r_base + ADDR_W'(r_idx);
  assign o_beat_idx = r_idx;
  assign o_last     = (r_idx == r_len - 1'b1);

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin burst arbiter sharing one single-port SRAM
// between several requesters; grant held for a whole burst.
module sram_port_arbiter
  import aes_sram_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      r_en,
  output logic                      w_en,
  output logic [ADDR_W-1:0]         addr,
  output logic [LEN_W-1:0]          beat_idx,
  output logic                      rvalid,
  output logic [NUM_REQ-1:0]        rvalid_id,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy
);

  arb_state_t r_state, w_nxt;

  logic [RR_W-1:0]    r_win, r_rr_ptr;
  logic [RR_W-1:0]    w_sel_idx, w_ptr_nxt;
  logic               r_we, w_sel_we;
  logic               r_rvalid;
  logic [NUM_REQ-1:0] r_rvalid_id, w_win_oh;
  logic [MAX_REQ-1:0] w_req_ext, w_pick;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [LEN_W-1:0]   w_sel_len;
  logic               w_any, w_grant, w_step;
  logic               w_adv, w_last, w_burst;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_REQ-1:0] = req;
  end

  assign w_pick = rr_pick(w_req_ext, r_rr_ptr,
                          unsigned'(NUM_REQ));
  assign w_any  = |w_pick;

  always_comb begin
    w_sel_idx  = '0;
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_sel_idx  = RR_W'(i);
        w_sel_we   = req_we[i];
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      w_win_oh[i] = (r_win == RR_W'(i));
  end

  assign w_ptr_nxt = (r_win == RR_W'(NUM_REQ - 1)) ?
                     '0 : r_win + 1'b1;

  always_comb begin
    w_nxt   = r_state;
    w_grant = 1'b0;
    w_step  = 1'b0;
    w_adv   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant = 1'b1;
          w_nxt   = (w_sel_len == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        // Owner withdrew: abandon silently, still rotate priority.
        if (!w_req_ext[r_win]) begin
          w_nxt = IDLE;
          w_adv = 1'b1;
        end else if (w_last) begin
          w_nxt = DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE: begin
        w_nxt = IDLE;
        w_adv = 1'b1;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_win       <= '0;
      r_we        <= 1'b0;
      r_rr_ptr    <= '0;
      r_rvalid    <= 1'b0;
      r_rvalid_id <= '0;
    end else begin
      if (w_grant) begin
        r_win <= w_sel_idx;
        r_we  <= w_sel_we;
      end
      if (w_adv) r_rr_ptr <= w_ptr_nxt;
      r_rvalid    <= r_en;
      r_rvalid_id <= r_en ? gnt : '0;
    end
  end

  burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_load     (w_grant),
    .i_step     (w_step),
    .i_base     (w_sel_addr),
    .i_len      (w_sel_len),
    .o_addr     (addr),
    .o_beat_idx (beat_idx),
    .o_last     (w_last)
  );

  assign w_burst   = (r_state == BURST);
  assign gnt       = w_burst ? w_win_oh : '0;
  assign r_en      = w_burst & ~r_we;
  assign w_en      = w_burst & r_we;
  assign done      = (r_state == DONE) ? w_win_oh : '0;
  assign busy      = (r_state != IDLE);
  assign rvalid    = r_rvalid;
  assign rvalid_id = r_rvalid_id;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: table vectors, corner sequences
// and a random run against a burst-level schedule model.
module tb_sram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N-1:0]    gnt, rvalid_id, done;
  logic            r_en, w_en, rvalid, busy;
  logic [AW-1:0]   addr;
  logic [LW-1:0]   beat_idx;
  logic [31:0]     w_all;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .gnt(gnt),
    .r_en(r_en), .w_en(w_en), .addr(addr), .beat_idx(beat_idx),
    .rvalid(rvalid), .rvalid_id(rvalid_id), .done(done),
    .busy(busy)
  );

  assign w_all = {3'b0, gnt, r_en, w_en, addr, beat_idx,
                  rvalid, rvalid_id, done, busy};

  typedef struct {
    int         rid;
    logic       we;
    logic [7:0] base;
    logic [7:0] len;
    int         n;
    int         done_t;
    logic [7:0] a0;
    logic [7:0] a1;
    int         rv;
  } vec_t;

  typedef struct packed {
    logic [2:0] gnt;
    logic       ren;
    logic       wen;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] dn;
    logic       bsy;
  } rec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we,
                         input logic [7:0] a, input logic [7:0] l);
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
    req[i]               = 1'b1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    req   = '0;
    step();
    step();
    n_rst = 1'b1;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int cnt, dt, bc, rv, bad, ft, lb;
    logic [7:0] fa, la;
    logic [2:0] oh;
    cnt = 0; dt = -1; bc = 0; rv = 0; bad = 0; ft = -1; lb = 0;
    fa = '0; la = '0;
    oh = 3'(1 << v.rid);
    set_req(v.rid, v.we, v.base, v.len);
    for (int t = 1; t <= 300; t++) begin
      step();
      if (r_en || w_en) begin
        cnt++;
        if (ft < 0) begin
          ft = t;
          fa = addr;
        end
        la = addr;
        lb = int'(beat_idx);
        if (gnt !== oh || w_en !== v.we || (r_en && w_en)) bad++;
      end
      if (rvalid) begin
        rv++;
        if (rvalid_id !== oh) bad++;
      end
      if (busy) bc++;
      if (done != '0) begin
        if (dt < 0) dt = t;
        if (done !== oh) bad++;
        req = '0;
      end
      if (dt >= 0 && t >= dt + 3) break;
    end
    req = '0;
    chk($sformatf("v%0d_strobes", vi), cnt, v.n);
    chk($sformatf("v%0d_done_cycle", vi), dt, v.done_t);
    chk($sformatf("v%0d_busy_cycles", vi), bc, v.n + 1);
    chk($sformatf("v%0d_rvalid_count", vi), rv, v.rv);
    chk($sformatf("v%0d_ownership", vi), bad, 0);
    if (v.n > 0) begin
      chk($sformatf("v%0d_first_cycle", vi), ft, 1);
      chk($sformatf("v%0d_first_addr", vi), fa, v.a0);
      chk($sformatf("v%0d_last_addr", vi), la, v.a1);
      chk($sformatf("v%0d_last_beat", vi), lb, v.n - 1);
    end
  endtask

  task automatic run_contention();
    int ord[$];
    int exp_ord[4];
    int viol, got;
    logic [2:0] prev;
    exp_ord = '{0, 1, 2, 0};
    viol = 0;
    prev = '0;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(i * 16), 8'd2);
    for (int t = 1; t <= 24; t++) begin
      step();
      if (gnt != '0 && prev == '0)
        ord.push_back(gnt == 3'b001 ? 0 : gnt == 3'b010 ? 1 :
                      gnt == 3'b100 ? 2 : 9);
      if ((gnt & (gnt - 3'd1)) != '0 || (r_en && w_en)) viol++;
      prev = gnt;
    end
    req = '0;
    for (int t = 0; t < 6; t++) step();
    for (int i = 0; i < 4; i++) begin
      got = (ord.size() > i) ? ord[i] : -1;
      chk($sformatf("contention_order%0d", i), got, exp_ord[i]);
    end
    chk("contention_onehot_excl", viol, 0);
  endtask

  task automatic run_abort();
    int d1;
    d1 = 0;
    do_reset();
    set_req(1, 1'b0, 8'h40, 8'd8);
    set_req(2, 1'b0, 8'h20, 8'd1);
    step();
    chk("abort_t1_gnt", gnt, 3'b010);
    chk("abort_t1_addr", addr, 8'h40);
    step();
    chk("abort_t2_addr", addr, 8'h41);
    chk("abort_t2_ren", r_en, 1'b1);
    req[1] = 1'b0;
    step();
    chk("abort_t3_idle", {gnt, r_en, w_en, done, busy}, '0);
    chk("abort_t3_rvalid_id", rvalid_id, 3'b010);
    step();
    chk("abort_t4_gnt", gnt, 3'b100);
    chk("abort_t4_addr", addr, 8'h20);
    req[2] = 1'b0;
    for (int t = 0; t < 5; t++) begin
      step();
      if (done[1]) d1++;
    end
    chk("abort_no_done1", d1, 0);
  endtask

  task automatic run_async_reset();
    int d1;
    d1 = 0;
    do_reset();
    set_req(1, 1'b0, 8'h90, 8'd8);
    step();
    set_req(0, 1'b0, 8'h05, 8'd1);
    step();
    step();
    chk("rst_beat3_idx", beat_idx, 8'd2);
    chk("rst_beat3_addr", addr, 8'h92);
    #2 n_rst = 1'b0;
    #1 chk("rst_async_outs", w_all, '0);
    #2 n_rst = 1'b1;
    step();
    chk("rst_regrant", gnt, 3'b001);
    chk("rst_regrant_addr", addr, 8'h05);
    req = 3'b001;
    for (int t = 0; t < 5; t++) begin
      step();
      if (done[1]) d1++;
    end
    chk("rst_no_done1", d1, 0);
    req = '0;
    for (int t = 0; t < 6; t++) step();
  endtask

  task automatic run_random(input int cycles);
    rec_t q[$];
    rec_t cur, prev, r, idle;
    int ptr, w, c, ln;
    logic we;
    logic [7:0] base;
    idle = '0;
    cur  = '0;
    prev = '0;
    ptr  = 0;
    do_reset();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(posedge clk);
      if (q.size() == 0 && req != '0) begin
        w = -1;
        for (int o = 0; o < N; o++) begin
          c = (ptr + o) % N;
          if (w < 0 && req[c]) w = c;
        end
        ptr  = (w + 1) % N;
        we   = req_we[w];
        base = req_addr[w*AW +: AW];
        ln   = int'(req_len[w*LW +: LW]);
        for (int j = 0; j < ln; j++) begin
          r     = idle;
          r.gnt = 3'(1 << w);
          r.ren = !we;
          r.wen = we;
          r.a   = 8'(int'(base) + j);
          r.b   = 8'(j);
          r.bsy = 1'b1;
          q.push_back(r);
        end
        r     = idle;
        r.dn  = 3'(1 << w);
        r.bsy = 1'b1;
        q.push_back(r);
        q.push_back(idle);
      end
      prev = cur;
      cur  = (q.size() > 0) ? q.pop_front() : idle;
      #1;
      chk($sformatf("rnd_gnt@%0d", cyc), gnt, cur.gnt);
      chk($sformatf("rnd_strobe@%0d", cyc), {r_en, w_en},
          {cur.ren, cur.wen});
      chk($sformatf("rnd_done@%0d", cyc), done, cur.dn);
      chk($sformatf("rnd_busy@%0d", cyc), busy, cur.bsy);
      chk($sformatf("rnd_rvalid@%0d", cyc), {rvalid, rvalid_id},
          {prev.ren, prev.ren ? prev.gnt : 3'b000});
      if (cur.ren || cur.wen)
        chk($sformatf("rnd_addr@%0d", cyc), {addr, beat_idx},
            {cur.a, cur.b});
      for (int i = 0; i < N; i++) begin
        if (cur.dn[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
          else set_req(i, 1'($urandom_range(1)),
                       8'($urandom_range(255)), 8'($urandom_range(6)));
        end else if (!req[i] && $urandom_range(3) == 0) begin
          set_req(i, 1'($urandom_range(1)),
                  8'($urandom_range(255)), 8'($urandom_range(6)));
        end
      end
    end
    req = '0;
    for (int t = 0; t < 12; t++) step();
  endtask

  initial begin
    vecs[0] = '{1, 1'b0, 8'h10, 8'd4,   4,   5,   8'h10, 8'h13, 4};
    vecs[1] = '{0, 1'b1, 8'hFE, 8'd3,   3,   4,   8'hFE, 8'h00, 0};
    vecs[2] = '{2, 1'b0, 8'h33, 8'd0,   0,   1,   8'h00, 8'h00, 0};
    vecs[3] = '{2, 1'b0, 8'hFF, 8'd1,   1,   2,   8'hFF, 8'hFF, 1};
    vecs[4] = '{1, 1'b1, 8'h7F, 8'd2,   2,   3,   8'h7F, 8'h80, 0};
    vecs[5] = '{0, 1'b0, 8'h80, 8'd255, 255, 256, 8'h80, 8'h7E, 255};

    n_rst = 1'b0;
    step();
    chk("reset_outs", w_all, '0);
    n_rst = 1'b1;
    step();
    chk("reset_idle_busy", busy, 1'b0);

    for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);
    run_contention();
    run_abort();
    run_async_reset();
    run_random(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Sequences and shares one single-port SRAM among up to NUM_REQ requesters, e.g. host data loader, key-expansion writer and cipher round-key reader. Each requester asks for a burst: start address, beat count and direction. The arbiter grants the port round-robin, holds the grant for the whole burst and generates one SRAM strobe and address per cycle. It sits between the AES datapath controllers and the SRAM macro, replacing per-client ad-hoc enable muxing.

## Interface
- NUM_REQ, 3, number of requesters (index 0 = highest initial priority)
- ADDR_W, 8, SRAM address width
- LEN_W, 8, burst-length width
- clk  input  1  system clock
- n_rst  input  1  reset, asynchronous, active-low
- req  input  NUM_REQ  per-requester burst request, level
- req_we  input  NUM_REQ  1 = write burst, 0 = read burst
- req_addr  input  NUM_REQ*ADDR_W  flattened start addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_len  input  NUM_REQ*LEN_W  flattened beat counts
- gnt  output  NUM_REQ  one-hot grant, held for the burst
- r_en  output  1  SRAM read strobe
- w_en  output  1  SRAM write strobe
- addr  output  ADDR_W  SRAM address
- beat_idx  output  LEN_W  index of the current beat (write requester selects data with it)
- rvalid  output  1  SRAM read data valid this cycle
- rvalid_id  output  NUM_REQ  one-hot owner of rvalid data
- done  output  NUM_REQ  one-cycle pulse per requester on burst completion
- busy  output  1  state != IDLE

## Operation
- States: IDLE, BURST, DONE.
- IDLE: if any req is high, pick the winner round-robin starting at rr_ptr. Latch winner, we, addr, len. Go to BURST, or to DONE if len == 0.
- BURST, one beat per cycle:
  - gnt[winner]=1
  - r_en = !we, w_en = we
  - addr = base + beat_idx, mod 2^ADDR_W (wraps 0xFF→0x00)
  - beat_idx counts 0..len-1
  - After the beat with beat_idx == len-1, go to DONE.
- DONE: done[winner]=1 for one cycle, gnt=0, no strobes. Set rr_ptr to winner+1 mod NUM_REQ. Next state is IDLE.
- Abort: if req[winner] drops while in BURST, no strobe is issued that cycle. Go to IDLE without a done pulse. rr_ptr still advances.
- Requesters hold req_we/req_addr/req_len stable from req rise until done. The arbiter latches them at grant, so later changes are ignored.
- A requester whose req stays high after done is re-arbitrated normally and sits at lowest priority.
- Outputs are registered (no combinational path from req to strobes).
- r_en and w_en are never high together. gnt is zero or one-hot.

## Timing
- Reset (async, n_rst=0): state IDLE, rr_ptr=0, all outputs 0, addr=0, beat_idx=0.
- Reset mid-burst: strobes drop immediately. No done pulse after release.
- Latency: req high in IDLE at edge k → gnt and first strobe in cycle k+1.
- Burst of N≥1 beats: strobes in cycles k+1..k+N, done in k+N+1, IDLE in k+N+2. Earliest next grant is k+N+3.
- len == 0: no strobes, done in cycle k+1.
- rvalid/rvalid_id: asserted one cycle after each r_en cycle (SRAM read latency 1). This includes the cycle after the last read beat, so it overlaps DONE.
- Simultaneous requests: only the winner is granted. Losers keep req high and wait, with no timeout.

## Structure
- Package aes_sram_pkg holds:
  - ADDR_W and LEN_W defaults
  - state enum arb_state_t {IDLE, BURST, DONE}
  - a round-robin pick function: one-hot winner from req and rr_ptr
- One sub-module, burst_addr_gen:
  - loads base and len, counts beat_idx
  - outputs addr = base + beat_idx and a last-beat flag
  - reused by other SRAM controllers
- The top holds the FSM, rr_ptr, winner/we latches and the rvalid pipeline register.

## Test plan
- Reset then single read: req[1]=1, we=0, addr=0x10, len=4 → gnt=3'b010 in cycles k+1..k+4. r_en with addr 0x10..0x13, rvalid in k+2..k+5 with rvalid_id=3'b010, done[1] in k+5.
- Write wrap: req[0], we=1, addr=0xFE, len=3 → w_en with addr 0xFE, 0xFF, 0x00. done[0] after the third beat.
- Contention: req=3'b111 from reset, all len=2, held high → grant order 0, 1, 2, 0. Strobes never overlap; gnt always zero or one-hot.
- len=0: req[2], len=0 → no strobes, done[2] in cycle k+1, busy high for exactly 1 cycle.
- Abort: req[1] drops after 2 of 8 beats → strobes stop that cycle, no done[1], IDLE next cycle, next grant goes to requester 2 if pending.
- Async reset mid-burst: n_rst low between edges during beat 3 → all outputs 0 immediately. After release, first grant goes to requester 0.
